// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier, one digit per cycle, signed or unsigned.
// Define BOOTH_MUL_EARLY_EXIT_EN to stop once the remaining multiplier bits are pure sign.
module booth_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int D  = WIDTH / 2 + 1;
    localparam int EW = WIDTH + 2;
    localparam int AW = 2 * WIDTH + 4;
    localparam int CW = $clog2(D);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        mcand_q, mcand_d;
    logic [EW:0]          mplr_q, mplr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic                 dig_one, dig_two, dig_neg;
    logic [AW-1:0]        mag;
    logic [AW-1:0]        addend;
    logic                 last_digit;
    logic                 a_sx, b_sx;

    // mplr_q[0] holds b_ext[2i-1]; it shifts right two bits per digit
    always_comb begin
        dig_one = 1'b0;
        dig_two = 1'b0;
        dig_neg = 1'b0;
        unique case (mplr_q[2:0])
            3'b001, 3'b010: dig_one = 1'b1;
            3'b011:         dig_two = 1'b1;
            3'b100: begin
                dig_two = 1'b1;
                dig_neg = 1'b1;
            end
            3'b101, 3'b110: begin
                dig_one = 1'b1;
                dig_neg = 1'b1;
            end
            default: ;
        endcase
        mag = '0;
        if (dig_two) begin
            mag = mcand_q << 1;
        end else if (dig_one) begin
            mag = mcand_q;
        end
        addend = dig_neg ? (~mag + AW'(1)) : mag;
    end

    always_comb begin
        last_digit = (cnt_q == CW'(D - 1));
`ifdef BOOTH_MUL_EARLY_EXIT_EN
        if ((&mplr_q[EW:2]) || !(|mplr_q[EW:2])) begin
            last_digit = 1'b1;
        end
`endif
    end

    assign a_sx = signed_mode & a[WIDTH-1];
    assign b_sx = signed_mode & b[WIDTH-1];

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        product_d = product_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    mcand_d = {{(AW - WIDTH){a_sx}}, a};
                    mplr_d  = {{2{b_sx}}, b, 1'b0};
                    cnt_d   = '0;
                    acc_d   = '0;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d   = acc_q + addend;
                mcand_d = mcand_q << 2;
                mplr_d  = {{2{mplr_q[EW]}}, mplr_q[EW:2]};
                cnt_d   = cnt_q + CW'(1);
                if (last_digit) begin
                    state_d   = S_DONE;
                    product_d = acc_d[2*WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplr_q    <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq (WIDTH=16) with an arithmetic reference model.
// Expected latency follows BOOTH_MUL_EARLY_EXIT_EN when it is defined.
module tb_booth_mul_seq;

    localparam int W = 16;
    localparam int D = W / 2 + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            signed_mode = 1'b0;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic            busy;
    logic            done;
    logic [2*W-1:0]  product;

    int              n_checks = 0;
    int              n_fail = 0;
    logic [2*W-1:0]  exp_prod = '0;
    logic            pending = 1'b0;
    int              exp_cyc = D;

    booth_mul_seq #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .signed_mode(signed_mode),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .product(product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] x,
                                                  input logic [W-1:0] y,
                                                  input logic sm);
        longint p;
        if (sm) p = longint'($signed(x)) * longint'($signed(y));
        else    p = longint'({48'b0, x}) * longint'({48'b0, y});
        return p[2*W-1:0];
    endfunction

    function automatic int model_cyc(input logic [W-1:0] y, input logic sm);
        longint v;
        v = sm ? longint'($signed(y)) : longint'({48'b0, y});
`ifdef BOOTH_MUL_EARLY_EXIT_EN
        for (int i = 0; i < D; i++) begin
            longint t;
            t = v >>> (2 * i + 1);
            if (t == 0 || t == -1) return i + 1;
        end
`else
        if (v == 0) return D;
`endif
        return D;
    endfunction

    // Single compare process: exclusivity every cycle, result on every done.
    always @(negedge clk) begin
        chk("busy_done_excl", {63'b0, busy & done}, 64'd0);
        if (done) begin
            chk("done_expected", {63'b0, pending}, 64'd1);
            pending = 1'b0;
            chk("product_model", {32'b0, product}, {32'b0, exp_prod});
        end
    end

    task automatic wait_done(input int base, output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                lat = base + c;
                break;
            end
        end
        if (lat < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got none expected done");
        end
    endtask

    // Caller sits at a negedge; b2b=1 drives start in the current cycle.
    task automatic accept(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic sm, input bit b2b);
        if (!b2b) @(negedge clk);
        start = 1'b1;
        a = ta;
        b = tb;
        signed_mode = sm;
        @(posedge clk);
        exp_prod = model_prod(ta, tb, sm);
        exp_cyc = model_cyc(tb, sm);
        pending = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", {63'b0, busy}, 64'd1);
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic sm, input bit b2b,
                         input logic [2*W-1:0] lit, input int lit_cyc);
        int lat;
        accept(ta, tb, sm, b2b);
        wait_done(0, lat);
        chk("latency_model", 64'(lat), 64'(exp_cyc));
        if (lit_cyc > 0) chk("latency_lit", 64'(lat), 64'(lit_cyc));
        chk("product_lit", {32'b0, product}, {32'b0, lit});
    endtask

    typedef struct {
        logic [W-1:0]   va;
        logic [W-1:0]   vb;
        logic           sm;
        logic [2*W-1:0] res;
    } vec_t;

    vec_t vecs[6] = '{
        '{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001},
        '{16'h8000, 16'h7FFF, 1'b1, 32'hC0008000},
        '{16'h0000, 16'hABCD, 1'b1, 32'h00000000},
        '{16'hFFFF, 16'h0001, 1'b1, 32'hFFFFFFFF},
        '{16'hFFFF, 16'h0001, 1'b0, 32'h0000FFFF},
        '{16'h8000, 16'h8000, 1'b0, 32'h40000000}
    };

    initial begin
        int lat;
        int stray;
        int ee_a;
        int ee_b;
`ifdef BOOTH_MUL_EARLY_EXIT_EN
        ee_a = 2;
        ee_b = 1;
`else
        ee_a = D;
        ee_b = D;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_done", {63'b0, done}, 64'd0);
        chk("reset_product", {32'b0, product}, 64'd0);
        rst = 1'b0;

        do_op(16'h8000, 16'h8000, 1'b1, 1'b0, 32'h40000000, D);
        do_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'hFFFE0001, 0);
        do_op(16'd1234, 16'hE9D2, 1'b1, 1'b0, 32'hFF951644, 0);

        // Start pulsed mid-run is ignored; start in DONE chains directly.
        accept(16'd3, 16'd5, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        start = 1'b1;
        a = 16'd9;
        b = 16'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done(3, lat);
        chk("ignore_latency", 64'(lat), 64'(D));
        chk("ignore_product", {32'b0, product}, 64'd15);
        do_op(16'd11, 16'd13, 1'b0, 1'b1, 32'd143, D);

        // Reset during RUN aborts without a done pulse.
        accept(16'd1234, 16'd3, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        pending = 1'b0;
        @(negedge clk);
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_done", {63'b0, done}, 64'd0);
        chk("abort_product", {32'b0, product}, 64'd0);
        rst = 1'b0;
        stray = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) stray++;
        end
        chk("abort_no_done", 64'(stray), 64'd0);
        do_op(16'd7, 16'd6, 1'b0, 1'b0, 32'd42, D);

        do_op(16'd100, 16'd3, 1'b1, 1'b0, 32'd300, ee_a);
        do_op(16'd100, 16'hFFFF, 1'b1, 1'b0, 32'hFFFFFF9C, ee_b);

        foreach (vecs[i]) begin
            do_op(vecs[i].va, vecs[i].vb, vecs[i].sm, 1'b0, vecs[i].res, 0);
        end

        repeat (3) @(negedge clk);
        chk("idle_after_done", {62'b0, busy, done}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

endmodule
